// File: rtl/autotune_pkg.sv
// Shared types and constants for the playback scheduler.
package autotune_pkg;

    typedef enum logic [0:0] {
        PB_PRIME = 1'b0,
        PB_PLAY  = 1'b1
    } pb_state_e;

    localparam int unsigned PB_PERIOD_W = 16;

    // A zero period would never tick; treat it as one word per clock.
    function automatic logic [PB_PERIOD_W-1:0] pb_period_sanitize(input logic [PB_PERIOD_W-1:0] p);
        return (p == '0) ? PB_PERIOD_W'(1) : p;
    endfunction

endpackage

// File: rtl/playback_scheduler_pb_ram.sv
// Simple dual-port storage for the playback ring FIFO; synchronous read, no reset on contents.
module pb_ram #(
    parameter int unsigned DEPTH      = 4400,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = 13
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port and read-first registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/playback_scheduler.sv
// Window-address ingest, ring FIFO and period-paced playback with prefill gating.
module playback_scheduler
    import autotune_pkg::*;
#(
    parameter int unsigned WINDOW_SIZE    = 2048,
    parameter int unsigned IN_WIDTH       = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 4400,
    parameter int unsigned PREFILL        = 2200,
    parameter int unsigned PERIOD_DEFAULT = 2304
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic [IN_WIDTH-1:0]            sample_in,
    input  logic                           sample_valid_in,
    output logic [IN_WIDTH-1:0]            win_sample_out,
    output logic [$clog2(WINDOW_SIZE)-1:0] win_addr_out,
    output logic                           win_valid_out,
    output logic                           win_last_out,
    input  logic [DATA_WIDTH-1:0]          wr_data_in,
    input  logic                           wr_valid_in,
    input  logic [PB_PERIOD_W-1:0]         period_in,
    input  logic                           period_valid_in,
    input  logic                           clear_in,
    output logic [DATA_WIDTH-1:0]          audio_out,
    output logic                           audio_valid_out,
    output logic                           underrun_out,
    output logic                           overflow_out,
    output logic [$clog2(DEPTH+1)-1:0]     level_out
);

    localparam int unsigned WIN_AW = $clog2(WINDOW_SIZE);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    pb_state_e              state;
    logic [WIN_AW-1:0]      win_cnt;
    logic [WIN_AW-1:0]      win_next;
    logic [PB_PERIOD_W-1:0] period_q;
    logic [PB_PERIOD_W-1:0] tick_cnt;
    logic                   tick;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic                   rd_pending;
    logic [DATA_WIDTH-1:0]  ram_q;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next window address, wrapping after the last slot.
    always_comb begin
        win_next = (win_cnt == WIN_AW'(WINDOW_SIZE - 1)) ? '0 : win_cnt + WIN_AW'(1);
    end

    // Ingest path: number each strobed sample and forward it one cycle later.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            win_cnt        <= WIN_AW'(WINDOW_SIZE - 1);
            win_sample_out <= '0;
            win_addr_out   <= '0;
            win_valid_out  <= 1'b0;
            win_last_out   <= 1'b0;
        end else begin
            win_valid_out <= sample_valid_in;
            win_last_out  <= sample_valid_in && (win_next == WIN_AW'(WINDOW_SIZE - 1));
            if (sample_valid_in) begin
                win_cnt        <= win_next;
                win_addr_out   <= win_next;
                win_sample_out <= sample_in;
            end
        end
    end

    assign tick = (tick_cnt == period_q - PB_PERIOD_W'(1));

    // Playback period register and free-running tick counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            period_q <= PB_PERIOD_W'(PERIOD_DEFAULT);
            tick_cnt <= '0;
        end else if (period_valid_in) begin
            period_q <= pb_period_sanitize(period_in);
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + PB_PERIOD_W'(1);
        end
    end

    // FIFO handshake: a pop frees a slot for a same-cycle write; clear wins over both.
    always_comb begin
        pop  = (state == PB_PLAY) && tick && (level_out != '0) && !clear_in;
        push = wr_valid_in && !clear_in && ((level_out != LVL_W'(DEPTH)) || pop);
        drop = wr_valid_in && !clear_in && !push;
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_out    <= '0;
            overflow_out <= 1'b0;
        end else if (clear_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_out    <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                level_out <= level_out + LVL_W'(1);
            end else if (pop && !push) begin
                level_out <= level_out - LVL_W'(1);
            end
            if (drop) begin
                overflow_out <= 1'b1;
            end
        end
    end

    // Playback FSM: wait for prefill, then pace pops; an empty tick signals underrun and re-primes.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= PB_PRIME;
            underrun_out <= 1'b0;
        end else begin
            underrun_out <= 1'b0;
            if (clear_in) begin
                state <= PB_PRIME;
            end else begin
                case (state)
                    PB_PRIME: begin
                        if (level_out >= LVL_W'(PREFILL)) begin
                            state <= PB_PLAY;
                        end
                    end
                    PB_PLAY: begin
                        if (tick && (level_out == '0)) begin
                            underrun_out <= 1'b1;
                            state        <= PB_PRIME;
                        end
                    end
                    default: state <= PB_PRIME;
                endcase
            end
        end
    end

    pb_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (PTR_W)
    ) u_ram (
        .clk     (clk_in),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_data_in),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // Output stage: the RAM word read after a pop is registered onto audio_out; in-flight reads survive clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_pending      <= 1'b0;
            audio_valid_out <= 1'b0;
            audio_out       <= '0;
        end else begin
            rd_pending      <= pop;
            audio_valid_out <= rd_pending;
            if (rd_pending) begin
                audio_out <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_playback_scheduler.sv
// Directed bench for playback_scheduler with a small FIFO (DEPTH=8, PREFILL=4).
module tb_playback_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic [15:0] win_sample_out;
    logic [10:0] win_addr_out;
    logic        win_valid_out;
    logic        win_last_out;
    logic [31:0] wr_data_in;
    logic        wr_valid_in;
    logic [15:0] period_in;
    logic        period_valid_in;
    logic        clear_in;
    logic [31:0] audio_out;
    logic        audio_valid_out;
    logic        underrun_out;
    logic        overflow_out;
    logic [3:0]  level_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int          ev_c[$];
    logic [31:0] ev_d[$];
    int          un_c[$];
    int          exp_c[$];
    logic [31:0] exp_d[$];
    int          exp_u[$];

    playback_scheduler #(
        .WINDOW_SIZE    (2048),
        .IN_WIDTH       (16),
        .DATA_WIDTH     (32),
        .DEPTH          (8),
        .PREFILL        (4),
        .PERIOD_DEFAULT (5)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .win_sample_out  (win_sample_out),
        .win_addr_out    (win_addr_out),
        .win_valid_out   (win_valid_out),
        .win_last_out    (win_last_out),
        .wr_data_in      (wr_data_in),
        .wr_valid_in     (wr_valid_in),
        .period_in       (period_in),
        .period_valid_in (period_valid_in),
        .clear_in        (clear_in),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .underrun_out    (underrun_out),
        .overflow_out    (overflow_out),
        .level_out       (level_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every played word and underrun pulse with its cycle number.
    always @(negedge clk) begin
        if (audio_valid_out) begin
            ev_c.push_back(cyc);
            ev_d.push_back(audio_out);
        end
        if (underrun_out) begin
            un_c.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_words(input int c0, input int step, input int n, input logic [31:0] d0);
        for (int k = 0; k < n; k++) begin
            exp_c.push_back(c0 + step * k);
            exp_d.push_back(d0 + 32'(k));
        end
    endtask

    // Compare recorded playback/underrun events against the expected lists, then reset both.
    task automatic check_events(input string tag);
        check_eq({tag, " words"}, 64'(ev_c.size()), 64'(exp_c.size()));
        check_eq({tag, " underruns"}, 64'(un_c.size()), 64'(exp_u.size()));
        for (int i = 0; i < ev_c.size() && i < exp_c.size(); i++) begin
            check_eq($sformatf("%s word%0d cycle", tag, i), 64'(ev_c[i]), 64'(exp_c[i]));
            check_eq($sformatf("%s word%0d data", tag, i), 64'(ev_d[i]), 64'(exp_d[i]));
        end
        for (int i = 0; i < un_c.size() && i < exp_u.size(); i++) begin
            check_eq($sformatf("%s underrun%0d cycle", tag, i), 64'(un_c[i]), 64'(exp_u[i]));
        end
        ev_c.delete();
        ev_d.delete();
        un_c.delete();
        exp_c.delete();
        exp_d.delete();
        exp_u.delete();
    endtask

    // Load period 5 in the current cycle and push four words in the next four cycles.
    task automatic play_four(input logic [31:0] d0, output int l);
        l               = cyc;
        period_valid_in = 1'b1;
        period_in       = 16'd5;
        @(negedge clk);
        period_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid_in = 1'b1;
            wr_data_in  = d0 + 32'(i);
            @(negedge clk);
        end
        wr_valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int l;
        int q;
        int p;
        int r;
        logic [10:0] ea;
        logic [15:0] es;

        rst_n           = 1'b0;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        wr_data_in      = '0;
        wr_valid_in     = 1'b0;
        period_in       = '0;
        period_valid_in = 1'b0;
        clear_in        = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst win_valid", 64'(win_valid_out), 64'd0);
        check_eq("rst win_addr", 64'(win_addr_out), 64'd0);
        check_eq("rst win_last", 64'(win_last_out), 64'd0);
        check_eq("rst win_sample", 64'(win_sample_out), 64'd0);
        check_eq("rst audio_valid", 64'(audio_valid_out), 64'd0);
        check_eq("rst audio", 64'(audio_out), 64'd0);
        check_eq("rst underrun", 64'(underrun_out), 64'd0);
        check_eq("rst overflow", 64'(overflow_out), 64'd0);
        check_eq("rst level", 64'(level_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Ingest: 2049 back-to-back strobes, each visible one cycle later.
        for (int i = 0; i <= 2049; i++) begin
            if (i > 0) begin
                ea = 11'((i - 1) % 2048);
                es = 16'((i - 1) * 3 + 7);
                check_eq($sformatf("ingest %0d", i - 1),
                         64'({win_valid_out, win_last_out, win_addr_out, win_sample_out}),
                         64'({1'b1, (i - 1) == 2047, ea, es}));
            end
            if (i < 2049) begin
                sample_valid_in = 1'b1;
                sample_in       = 16'(i * 3 + 7);
            end else begin
                sample_valid_in = 1'b0;
            end
            @(negedge clk);
        end
        check_eq("ingest idle valid", 64'(win_valid_out), 64'd0);

        // Prefill, paced playback, drain to underrun, then refill.
        play_four(32'd100, l);
        check_eq("prefill level", 64'(level_out), 64'd4);
        wait_to(l + 33);
        expect_words(l + 12, 5, 4, 32'd100);
        exp_u.push_back(l + 31);
        check_events("play");
        check_eq("drained level", 64'(level_out), 64'd0);
        wait_to(l + 36);
        for (int i = 0; i < 4; i++) begin
            wr_valid_in = 1'b1;
            wr_data_in  = 32'd104 + 32'(i);
            @(negedge clk);
        end
        wr_valid_in = 1'b0;
        wait_to(l + 68);
        expect_words(l + 47, 5, 4, 32'd104);
        exp_u.push_back(l + 66);
        check_events("refill");

        // Overflow: ten writes into eight slots with no ticks.
        q               = cyc;
        period_valid_in = 1'b1;
        period_in       = 16'd1000;
        @(negedge clk);
        period_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_valid_in = 1'b1;
            wr_data_in  = 32'd200 + 32'(i);
            @(negedge clk);
        end
        wr_valid_in = 1'b0;
        check_eq("full level", 64'(level_out), 64'd8);
        check_eq("overflow set", 64'(overflow_out), 64'd1);

        // Period 0 acts as 1; a write alongside the first pop while full is accepted.
        p               = cyc;
        period_valid_in = 1'b1;
        period_in       = 16'd0;
        @(negedge clk);
        period_valid_in = 1'b0;
        wr_valid_in     = 1'b1;
        wr_data_in      = 32'd210;
        @(negedge clk);
        wr_valid_in = 1'b0;
        check_eq("push+pop level", 64'(level_out), 64'd8);
        wait_to(p + 13);
        expect_words(p + 3, 1, 8, 32'd200);
        expect_words(p + 11, 1, 1, 32'd210);
        exp_u.push_back(p + 11);
        check_events("period0");
        check_eq("overflow sticky", 64'(overflow_out), 64'd1);
        check_eq("period0 level", 64'(level_out), 64'd0);

        // Period change from 1 to 3 while playing.
        r = cyc;
        for (int i = 0; i < 6; i++) begin
            wr_valid_in = 1'b1;
            wr_data_in  = 32'd300 + 32'(i);
            @(negedge clk);
        end
        wr_valid_in     = 1'b0;
        period_valid_in = 1'b1;
        period_in       = 16'd3;
        @(negedge clk);
        period_valid_in = 1'b0;
        wait_to(r + 24);
        expect_words(r + 7, 1, 2, 32'd300);
        expect_words(r + 11, 3, 4, 32'd302);
        exp_u.push_back(r + 22);
        check_events("period3");

        // Clear mid-play with a simultaneous write; the in-flight word still emerges.
        play_four(32'd400, l);
        check_eq("pre-clear overflow", 64'(overflow_out), 64'd1);
        wait_to(l + 16);
        clear_in    = 1'b1;
        wr_valid_in = 1'b1;
        wr_data_in  = 32'd499;
        @(negedge clk);
        clear_in    = 1'b0;
        wr_valid_in = 1'b0;
        check_eq("clear level", 64'(level_out), 64'd0);
        check_eq("clear overflow", 64'(overflow_out), 64'd0);
        wait_to(l + 28);
        expect_words(l + 12, 5, 2, 32'd400);
        check_events("clear");
        play_four(32'd410, l);
        wait_to(l + 33);
        expect_words(l + 12, 5, 4, 32'd410);
        exp_u.push_back(l + 31);
        check_events("after clear");

        // Asynchronous reset mid-play, then restart.
        play_four(32'd500, l);
        wait_to(l + 12);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async rst level", 64'(level_out), 64'd0);
        check_eq("async rst valid", 64'(audio_valid_out), 64'd0);
        check_eq("async rst audio", 64'(audio_out), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        expect_words(l + 12, 5, 1, 32'd500);
        check_events("reset");
        check_eq("post rst level", 64'(level_out), 64'd0);
        check_eq("post rst audio", 64'(audio_out), 64'd0);
        play_four(32'd510, l);
        wait_to(l + 33);
        expect_words(l + 12, 5, 4, 32'd510);
        exp_u.push_back(l + 31);
        check_events("after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
